// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit saturating-counter branch direction predictor with redirect and statistics
//
// Purpose:
//   Predicts branch direction from a table of 2-bit saturating counters.
//   The table is indexed by the low PC bits. At resolve time the block
//   trains the table and counts branches and mispredicts. On a mispredict
//   it issues a one-cycle redirect to the correct target.
//
// Ports:
//   clk, reset          : single clock; synchronous active-low reset
//   fetch_valid/_pc     : lookup request
//   pred_valid/_taken   : registered prediction for the previous cycle's lookup
//   pred_pc             : echo of the looked-up PC
//   resolve_*           : actual outcome of a branch, with the prediction
//                         that was carried down the pipe
//   redirect_valid/_pc  : registered one-cycle recovery request
//   branch_count        : saturating count of resolved branches
//   mispredict_count    : saturating count of mispredicts
module branch_predictor #(
    parameter int PC_W    = 16,
    parameter int IMM_W   = 16,
    parameter int IDX_W   = 4,
    parameter int TGT_ADJ = 4,
    parameter int FT_ADJ  = 6,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic [PC_W-1:0]  fetch_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_pc,
    input  logic             resolve_valid,
    input  logic [PC_W-1:0]  resolve_pc,
    input  logic [IMM_W-1:0] resolve_imm,
    input  logic             resolve_taken,
    input  logic             resolve_pred,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]       table_q [ENTRIES];
    logic [1:0]       table_d [ENTRIES];
    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic [PC_W-1:0]  pred_pc_q, pred_pc_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] resolve_idx;
    logic             mispredict;
    logic [PC_W-1:0]  imm_ext;
    logic [PC_W-1:0]  taken_tgt;
    logic [PC_W-1:0]  fall_tgt;

    assign fetch_idx   = fetch_pc[IDX_W-1:0];
    assign resolve_idx = resolve_pc[IDX_W-1:0];
    assign mispredict  = resolve_valid && (resolve_pred != resolve_taken);

    // A width cast of a signed operand sign-extends. This also covers IMM_W == PC_W.
    assign imm_ext   = PC_W'($signed(resolve_imm));
    assign taken_tgt = resolve_pc + imm_ext - PC_W'(TGT_ADJ);
    assign fall_tgt  = resolve_pc - PC_W'(FT_ADJ);

    always_comb begin
        // Lookup reads the pre-update table. A same-cycle update to the
        // same entry is seen only by later lookups.
        pred_valid_d = fetch_valid && !mispredict;
        pred_taken_d = pred_taken_q;
        pred_pc_d    = pred_pc_q;
        if (fetch_valid) begin
            pred_taken_d = table_q[fetch_idx][1];
            pred_pc_d    = fetch_pc;
        end

        redirect_valid_d = mispredict;
        redirect_pc_d    = redirect_pc_q;
        if (mispredict) begin
            redirect_pc_d = resolve_taken ? taken_tgt : fall_tgt;
        end

        table_d = table_q;
        if (resolve_valid) begin
            if (resolve_taken && table_q[resolve_idx] != 2'b11) begin
                table_d[resolve_idx] = table_q[resolve_idx] + 2'b01;
            end else if (!resolve_taken && table_q[resolve_idx] != 2'b00) begin
                table_d[resolve_idx] = table_q[resolve_idx] - 2'b01;
            end
        end

        branch_count_d = branch_count_q;
        if (resolve_valid && branch_count_q != {CNT_W{1'b1}}) begin
            branch_count_d = branch_count_q + 1'b1;
        end

        mispredict_count_d = mispredict_count_q;
        if (mispredict && mispredict_count_q != {CNT_W{1'b1}}) begin
            mispredict_count_d = mispredict_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= 2'b01;
            end
            pred_valid_q       <= 1'b0;
            pred_taken_q       <= 1'b0;
            pred_pc_q          <= '0;
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            table_q            <= table_d;
            pred_valid_q       <= pred_valid_d;
            pred_taken_q       <= pred_taken_d;
            pred_pc_q          <= pred_pc_d;
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign pred_valid       = pred_valid_q;
    assign pred_taken       = pred_taken_q;
    assign pred_pc          = pred_pc_q;
    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [15:0] fetch_pc;
    logic        resolve_valid;
    logic [15:0] resolve_pc;
    logic [15:0] resolve_imm;
    logic        resolve_taken;
    logic        resolve_pred;

    logic        pred_valid, pred_taken, redirect_valid;
    logic [15:0] pred_pc, redirect_pc, branch_count, mispredict_count;
    logic        pv4, pt4, rv4;
    logic [15:0] ppc4, rpc4;
    logic [3:0]  bc4, mc4;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int tbl [16];
    bit          m_pv, m_pt, m_rv;
    logic [15:0] m_ppc, m_rpc;
    int          m_bc, m_mc, m_bc4, m_mc4;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_imm(resolve_imm),
        .resolve_taken(resolve_taken), .resolve_pred(resolve_pred),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    branch_predictor #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_valid(pv4), .pred_taken(pt4), .pred_pc(ppc4),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_imm(resolve_imm),
        .resolve_taken(resolve_taken), .resolve_pred(resolve_pred),
        .redirect_valid(rv4), .redirect_pc(rpc4),
        .branch_count(bc4), .mispredict_count(mc4)
    );

    task automatic drive(input bit fv, input logic [15:0] fpc, input bit rv,
                         input logic [15:0] rpc, input logic [15:0] rimm,
                         input bit rt, input bit rp);
        fetch_valid   = fv;
        fetch_pc      = fpc;
        resolve_valid = rv;
        resolve_pc    = rpc;
        resolve_imm   = rimm;
        resolve_taken = rt;
        resolve_pred  = rp;
    endtask

    // Advance the model by one clock with the current inputs, then clock the DUT.
    task automatic step();
        bit mis;
        int idx;
        if (!reset) begin
            for (int i = 0; i < 16; i++) tbl[i] = 1;
            m_pv = 0; m_pt = 0; m_ppc = 0; m_rv = 0; m_rpc = 0;
            m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
        end else begin
            mis  = resolve_valid && (resolve_pred != resolve_taken);
            m_pv = fetch_valid && !mis;
            if (fetch_valid) begin
                m_pt  = tbl[int'(fetch_pc) % 16] >= 2;
                m_ppc = fetch_pc;
            end
            m_rv = mis;
            if (mis) begin
                if (resolve_taken)
                    m_rpc = 16'(int'(resolve_pc) + int'($signed(resolve_imm)) - 4);
                else
                    m_rpc = 16'(int'(resolve_pc) - 6);
            end
            if (resolve_valid) begin
                idx = int'(resolve_pc) % 16;
                if (resolve_taken) tbl[idx] = (tbl[idx] < 3) ? tbl[idx] + 1 : 3;
                else               tbl[idx] = (tbl[idx] > 0) ? tbl[idx] - 1 : 0;
                m_bc  = (m_bc  < 65535) ? m_bc + 1  : m_bc;
                m_bc4 = (m_bc4 < 15)    ? m_bc4 + 1 : m_bc4;
                if (mis) begin
                    m_mc  = (m_mc  < 65535) ? m_mc + 1  : m_mc;
                    m_mc4 = (m_mc4 < 15)    ? m_mc4 + 1 : m_mc4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1, 16'h0003, 1, 16'h0003, 16'h0010, 1, 0);
        step();
        step();
        checks++;
        if ({pred_valid, pred_taken, pred_pc, redirect_valid, redirect_pc} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: pv=%0b pt=%0b ppc=%h rv=%0b rpc=%h want all 0",
                     pred_valid, pred_taken, pred_pc, redirect_valid, redirect_pc);
        end
        checks++;
        if (branch_count !== 16'd0 || mispredict_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: bc=%0d mc=%0d want 0 0", branch_count, mispredict_count);
        end
        reset = 1'b1;
    endtask

    task automatic test_lookup();
        drive(1, 16'h0010, 0, 16'h0, 16'h0, 0, 0);
        step();
        checks++;
        if ({pred_valid, pred_taken, pred_pc} !== {1'b1, 1'b0, 16'h0010}) begin
            errors++;
            $display("FAIL lookup_first: pv=%0b pt=%0b ppc=%h want 1 0 0010",
                     pred_valid, pred_taken, pred_pc);
        end
        drive(0, 16'h0010, 0, 16'h0, 16'h0, 0, 0);
        step();
        checks++;
        if (pred_valid !== 1'b0) begin
            errors++;
            $display("FAIL lookup_idle: pv=%0b want 0", pred_valid);
        end
    endtask

    task automatic test_redirect();
        drive(0, 16'h0, 1, 16'h0010, 16'h0020, 1, 0);
        step();
        checks++;
        if ({redirect_valid, redirect_pc, mispredict_count} !== {1'b1, 16'h002C, 16'd1}) begin
            errors++;
            $display("FAIL redirect_taken: rv=%0b rpc=%h mc=%0d want 1 002c 1",
                     redirect_valid, redirect_pc, mispredict_count);
        end
        drive(1, 16'h0000, 0, 16'h0, 16'h0, 0, 0);
        step();
        checks++;
        if ({redirect_valid, redirect_pc, pred_valid, pred_taken} !== {1'b0, 16'h002C, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL redirect_hold_entry0: rv=%0b rpc=%h pv=%0b pt=%0b want 0 002c 1 1",
                     redirect_valid, redirect_pc, pred_valid, pred_taken);
        end
        // Back-to-back mispredicts, each with its own target, including a wrapping one.
        drive(0, 16'h0, 1, 16'h0100, 16'h0, 0, 1);
        step();
        checks++;
        if ({redirect_valid, redirect_pc} !== {1'b1, 16'h00FA}) begin
            errors++;
            $display("FAIL redirect_fallthrough: rv=%0b rpc=%h want 1 00fa", redirect_valid, redirect_pc);
        end
        drive(0, 16'h0, 1, 16'h0002, 16'hFFFC, 1, 0);
        step();
        checks++;
        if ({redirect_valid, redirect_pc} !== {1'b1, 16'hFFFA}) begin
            errors++;
            $display("FAIL redirect_wrap: rv=%0b rpc=%h want 1 fffa", redirect_valid, redirect_pc);
        end
        drive(0, 16'h0, 0, 16'h0, 16'h0, 0, 0);
        step();
        checks++;
        if ({redirect_valid, redirect_pc} !== {1'b0, 16'hFFFA}) begin
            errors++;
            $display("FAIL redirect_one_cycle: rv=%0b rpc=%h want 0 fffa", redirect_valid, redirect_pc);
        end
    endtask

    task automatic test_saturate();
        // The first update races a lookup of the same entry; the lookup sees the old weak-NT state.
        drive(1, 16'h0003, 1, 16'h0003, 16'h0, 1, 1);
        step();
        checks++;
        if ({pred_valid, pred_taken} !== 2'b10) begin
            errors++;
            $display("FAIL same_cycle_lookup: pv=%0b pt=%0b want 1 0", pred_valid, pred_taken);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 16'h0, 1, 16'h0003, 16'h0, 1, 1);
            step();
        end
        // From strong-T, one not-taken leaves weak-T, so the prediction is still taken.
        drive(0, 16'h0, 1, 16'h0003, 16'h0, 0, 0);
        step();
        drive(1, 16'h0013, 0, 16'h0, 16'h0, 0, 0);
        step();
        checks++;
        if ({pred_valid, pred_taken, pred_pc} !== {1'b1, 1'b1, 16'h0013}) begin
            errors++;
            $display("FAIL saturate_entry3: pv=%0b pt=%0b ppc=%h want 1 1 0013",
                     pred_valid, pred_taken, pred_pc);
        end
    endtask

    task automatic test_squash_reset();
        drive(1, 16'h0005, 1, 16'h0020, 16'h0004, 1, 0);
        step();
        checks++;
        if ({pred_valid, redirect_valid} !== 2'b01) begin
            errors++;
            $display("FAIL squash: pv=%0b rv=%0b want 0 1", pred_valid, redirect_valid);
        end
        reset = 1'b0;
        drive(1, 16'h0005, 1, 16'h0020, 16'h0004, 1, 0);
        step();
        reset = 1'b1;
        checks++;
        if ({pred_valid, pred_taken, pred_pc, redirect_valid, redirect_pc,
             branch_count, mispredict_count} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid_redirect: pv=%0b pt=%0b ppc=%h rv=%0b rpc=%h bc=%0d mc=%0d want all 0",
                     pred_valid, pred_taken, pred_pc, redirect_valid, redirect_pc,
                     branch_count, mispredict_count);
        end
    endtask

    task automatic test_count_sat();
        for (int i = 0; i < 17; i++) begin
            drive(0, 16'h0, 1, 16'(i), 16'h0, 1, 0);
            step();
        end
        checks++;
        if ({bc4, mc4} !== 8'hFF) begin
            errors++;
            $display("FAIL count_sat4: bc4=%h mc4=%h want f f", bc4, mc4);
        end
        checks++;
        if (branch_count !== 16'(m_bc) || mispredict_count !== 16'(m_mc)) begin
            errors++;
            $display("FAIL count_wide: bc=%0d mc=%0d want %0d %0d",
                     branch_count, mispredict_count, m_bc, m_mc);
        end
    endtask

    task automatic test_random();
        int bad;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) != 0);
            drive($urandom_range(0, 1) == 1, 16'($urandom_range(0, 40)),
                  $urandom_range(0, 2) != 0, 16'($urandom),
                  16'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            step();
            bad = 0;
            checks++;
            if (pred_valid !== m_pv || redirect_valid !== m_rv || redirect_pc !== m_rpc ||
                branch_count !== 16'(m_bc) || mispredict_count !== 16'(m_mc) ||
                bc4 !== 4'(m_bc4) || mc4 !== 4'(m_mc4)) bad = 1;
            if (m_pv && (pred_taken !== m_pt || pred_pc !== m_ppc)) bad = 1;
            if (bad != 0) begin
                errors++;
                $display("FAIL random_cycle%0d: pv=%0b pt=%0b ppc=%h rv=%0b rpc=%h bc=%0d mc=%0d bc4=%0d mc4=%0d want pv=%0b pt=%0b ppc=%h rv=%0b rpc=%h bc=%0d mc=%0d bc4=%0d mc4=%0d",
                         n, pred_valid, pred_taken, pred_pc, redirect_valid, redirect_pc,
                         branch_count, mispredict_count, bc4, mc4,
                         m_pv, m_pt, m_ppc, m_rv, m_rpc, m_bc, m_mc, m_bc4, m_mc4);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 16'h0, 0, 16'h0, 16'h0, 0, 0);
        @(posedge clk);
        #1;
        test_reset();
        test_lookup();
        test_redirect();
        test_saturate();
        test_squash_reset();
        test_count_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PC_W, default 16, PC and target width in bits.
REQ-002 SHALL have parameter IMM_W, default 16, branch immediate width (IMM_W <= PC_W), two's complement.
REQ-003 SHALL have parameter IDX_W, default 4, history table index width (2^IDX_W entries).
REQ-004 SHALL have parameter TGT_ADJ, default 4, subtracted from pc+imm for the taken target.
REQ-005 SHALL have parameter FT_ADJ, default 6, subtracted from pc for the not-taken (fall-through) target.
REQ-006 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-007 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-008 SHALL have ports: reset  input  1  synchronous, active-low reset.
REQ-009 SHALL have ports: fetch_valid  input  1  lookup request; fetch_pc  input  PC_W  PC to predict.
REQ-010 SHALL have ports: pred_valid  output  1; pred_taken  output  1; pred_pc  output  PC_W  registered prediction for the previous cycle's lookup.
REQ-011 SHALL have ports: resolve_valid  input  1; resolve_pc  input  PC_W; resolve_imm  input  IMM_W; resolve_taken  input  1  actual outcome; resolve_pred  input  1  prediction carried down the pipe.
REQ-012 SHALL have ports: redirect_valid  output  1; redirect_pc  output  PC_W  registered recovery target.
REQ-013 SHALL have ports: branch_count  output  CNT_W; mispredict_count  output  CNT_W.

Function
REQ-014 SHALL hold a table of 2^IDX_W 2-bit saturating counters indexed by pc[IDX_W-1:0]; states 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; predict taken iff bit 1 set.
REQ-015 Lookup SHALL have latency 1: with fetch_valid high at edge N, pred_valid=1 and pred_taken = table MSB of fetch_pc's entry are presented after edge N; pred_valid=0 otherwise.
REQ-016 Prediction SHALL provide only the direction; pred_pc SHALL echo the looked-up fetch_pc (the target is not known at fetch).
REQ-017 Resolve-side target arithmetic SHALL be modulo 2^PC_W with resolve_imm sign-extended to PC_W: taken target = pc + sext(imm) - TGT_ADJ; fall-through = pc - FT_ADJ.
REQ-018 Mispredict SHALL be resolve_valid && (resolve_pred != resolve_taken).
REQ-019 On mispredict at edge N, redirect_valid SHALL be 1 for exactly one cycle after edge N, with redirect_pc = taken target if resolve_taken else fall-through; otherwise redirect_valid=0 and redirect_pc holds its last value.
REQ-020 On mispredict at edge N, pred_valid SHALL be forced 0 after edge N regardless of fetch_valid (squash of wrong-path lookup).
REQ-021 On resolve_valid, the entry at resolve_pc SHALL increment if taken, decrement if not, saturating at 11 and 00.
REQ-022 Same-cycle lookup and update of one entry: lookup SHALL return the pre-update value; the update SHALL take effect.
REQ-023 branch_count SHALL increment on every resolve_valid; mispredict_count on every mispredict; both SHALL saturate at all-ones and never wrap.
REQ-024 Back-to-back mispredicts on consecutive cycles SHALL each produce a one-cycle redirect with its own target.

Reset
REQ-025 When reset=0 at a clock edge: every table entry -> 01, pred_valid=0, pred_taken=0, pred_pc=0, redirect_valid=0, redirect_pc=0, both counts=0.
REQ-026 Reset SHALL take priority over all lookups and resolves in the same cycle; an in-flight redirect is discarded.
REQ-027 No state SHALL change asynchronously to clk.

Verification
REQ-028 After reset, fetch_valid=1, fetch_pc=0x0010 -> next cycle pred_valid=1, pred_taken=0, pred_pc=0x0010.
REQ-029 Resolve pc=0x0010, taken=1, pred=0, imm=0x0020 -> redirect_valid=1 one cycle, redirect_pc=0x002C; entry 0 -> 10; mispredict_count=1.
REQ-030 Resolve pc=0x0100, taken=0, pred=1 -> redirect_pc=0x00FA; resolve pc=0x0002, imm=0xFFFC (-4), taken=1, pred=0 -> redirect_pc=0xFFFA (wrap).
REQ-031 Four consecutive taken resolves on entry 3 -> state 11 and stays 11; fetch same cycle as first update still predicts not-taken.
REQ-032 Mispredict at cycle N with fetch_valid=1 -> pred_valid=0 at N+1; reset asserted at N+1 mid-redirect -> all outputs zero at N+2.
REQ-033 With CNT_W=4, 17 resolves -> branch_count stays 0xF.
